// File: rtl/mem_arbiter.sv
// Main-memory bus arbiter between the icache prefetcher and the dcache: combinational grant,
// registered tag-ownership table so returning load data reaches only the side that issued it.
module mem_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned NUM_TAGS     = 16,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic [1:0]                  i_icache_command,
    input  logic [XLEN-1:0]             i_icache_addr,
    input  logic [1:0]                  i_dcache_command,
    input  logic [XLEN-1:0]             i_dcache_addr,
    input  logic [63:0]                 i_dcache_data,
    input  logic [$clog2(NUM_TAGS)-1:0] i_mem2proc_response,
    input  logic [63:0]                 i_mem2proc_data,
    input  logic [$clog2(NUM_TAGS)-1:0] i_mem2proc_tag,
    output logic [1:0]                  o_proc2mem_command,
    output logic [XLEN-1:0]             o_proc2mem_addr,
    output logic [63:0]                 o_proc2mem_data,
    output logic                        o_give_way,
    output logic [$clog2(NUM_TAGS)-1:0] o_icache_response,
    output logic [$clog2(NUM_TAGS)-1:0] o_dcache_response,
    output logic [$clog2(NUM_TAGS)-1:0] o_icache_tag,
    output logic [$clog2(NUM_TAGS)-1:0] o_dcache_tag,
    output logic [63:0]                 o_mem_data_out,
    output logic                        o_stray_tag_err
);

    localparam int unsigned TAG_W = $clog2(NUM_TAGS);
    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] BUS_NONE  = 2'd0;
    localparam logic [1:0] BUS_LOAD  = 2'd1;

    logic [NUM_TAGS-1:0] r_valid;
    logic [NUM_TAGS-1:0] r_owner;     // 0 = icache, 1 = dcache
    logic [CNT_W-1:0]    r_starve_cnt;
    logic                r_stray_err;

    logic w_i_req;
    logic w_d_req;
    logic w_grant_i;
    logic w_grant_d;
    logic w_alloc;
    logic w_tag_hit;
    logic w_tag_stray;

    always_comb begin
        w_i_req   = (i_icache_command != BUS_NONE);
        w_d_req   = (i_dcache_command != BUS_NONE);
        w_grant_i = w_i_req && (!w_d_req || (r_starve_cnt == CNT_W'(STARVE_LIMIT)));
        w_grant_d = w_d_req && !w_grant_i;

        o_proc2mem_command = BUS_NONE;
        o_proc2mem_addr    = '0;
        o_proc2mem_data    = '0;
        if (w_grant_i) begin
            o_proc2mem_command = i_icache_command;
            o_proc2mem_addr    = i_icache_addr;
        end else if (w_grant_d) begin
            o_proc2mem_command = i_dcache_command;
            o_proc2mem_addr    = i_dcache_addr;
            o_proc2mem_data    = i_dcache_data;
        end

        o_give_way        = w_i_req && w_grant_d;
        o_icache_response = w_grant_i ? i_mem2proc_response : '0;
        o_dcache_response = w_grant_d ? i_mem2proc_response : '0;

        // Only granted loads that memory accepted get an owner entry.
        w_alloc = (o_proc2mem_command == BUS_LOAD) && (i_mem2proc_response != '0);

        // Table contents are not trusted while reset is held.
        w_tag_hit   = !reset && (i_mem2proc_tag != '0) && r_valid[i_mem2proc_tag];
        w_tag_stray = !reset && (i_mem2proc_tag != '0) && !r_valid[i_mem2proc_tag];

        o_icache_tag    = (w_tag_hit && !r_owner[i_mem2proc_tag]) ? i_mem2proc_tag : '0;
        o_dcache_tag    = (w_tag_hit && r_owner[i_mem2proc_tag]) ? i_mem2proc_tag : '0;
        o_mem_data_out  = i_mem2proc_data;
        o_stray_tag_err = r_stray_err;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid      <= '0;
            r_owner      <= '0;
            r_starve_cnt <= '0;
            r_stray_err  <= 1'b0;
        end else begin
            if (w_tag_hit) begin
                r_valid[i_mem2proc_tag] <= 1'b0;
            end
            // Later assignment lets a same-cycle reissue of the returning tag win.
            if (w_alloc) begin
                r_valid[i_mem2proc_response] <= 1'b1;
                r_owner[i_mem2proc_response] <= w_grant_d;
            end
            if (w_tag_stray) begin
                r_stray_err <= 1'b1;
            end
            if (w_grant_i || !w_i_req) begin
                r_starve_cnt <= '0;
            end else if (o_give_way && (r_starve_cnt != CNT_W'(STARVE_LIMIT))) begin
                r_starve_cnt <= r_starve_cnt + CNT_W'(1);
            end
        end
    end

endmodule
